// File: rtl/ring_timing_monitor.sv
// ring_timing_monitor
// Watches the word from a 6-bit one-hot ring counter and tracks its phase.
// Reports whether each sampled word followed the legal sequence, keeps a
// sticky error flag with a saturating error count, and counts completed
// 6-phase cycles.
//
// State is visible on the locked output: locked=1 <=> LOCKED, locked=0 <=> HUNT.
// The block has no handshake. Every output is registered and updates on every
// clock edge. valid qualifies phase for the word sampled at that edge.
module ring_timing_monitor #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       T_in,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [5:0] START_WORD = 6'b100000;
  localparam logic [5:0] LAST_WORD  = 6'b000001;

  state_t     state;
  logic [5:0] last_word;   // last word accepted while in lock
  logic [5:0] expected;
  logic       is_match;
  logic       is_start;
  logic       err_sat;
  logic [2:0] word_idx;

  // Next legal word after the last accepted one, plus decode of T_in.
  always_comb begin
    expected = (last_word == LAST_WORD) ? START_WORD : (last_word >> 1);
    is_match = (T_in == expected);
    is_start = (T_in == START_WORD);
    err_sat  = &err_cnt;
    word_idx = 3'd0;
    case (T_in)
      6'b100000: word_idx = 3'd0;
      6'b010000: word_idx = 3'd1;
      6'b001000: word_idx = 3'd2;
      6'b000100: word_idx = 3'd3;
      6'b000010: word_idx = 3'd4;
      6'b000001: word_idx = 3'd5;
      default:   word_idx = 3'd0;
    endcase
  end

  // Lock FSM with registered outputs. A clear request overrides an error raised on the same edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= HUNT;
      last_word <= 6'b000000;
      phase     <= 3'd0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      cycle_cnt <= '0;
    end else begin
      if (clr_err) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
      case (state)
        HUNT: begin
          if (is_start) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            phase     <= 3'd0;
            valid     <= 1'b1;
            last_word <= T_in;
          end else begin
            valid <= 1'b0;
          end
        end
        LOCKED: begin
          if (is_match) begin
            valid     <= 1'b1;
            phase     <= word_idx;
            last_word <= T_in;
            if (last_word == LAST_WORD) begin
              cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
          end else begin
            if (!clr_err) begin
              err <= 1'b1;
              if (!err_sat) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end
            end
            // A start word after a mismatch means the source restarted: relock immediately.
            if (is_start) begin
              phase     <= 3'd0;
              valid     <= 1'b1;
              last_word <= T_in;
            end else begin
              state  <= HUNT;
              locked <= 1'b0;
              valid  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
          valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
